// File: rtl/out_strobe_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : out_strobe_gen_if
// Brief   : Valid/ready command-word channel feeding the output strobe generator.
// Revision: 1.0 - initial release
// ============================================================================
interface out_strobe_gen_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/out_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module  : out_strobe_gen
// Brief   : Decodes output commands into fixed-width one-hot strobes with hold-off.
// Revision: 1.0 - initial release
// ============================================================================
package cmd_icd_pkg;
  localparam logic [7:0] OUT_CMD_OPCODE = 8'hA5;
endpackage

module out_strobe_gen #(
  parameter int unsigned PULSE_CYCLES   = 16,
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter logic [7:0]  CMD_OUT_OPCODE = cmd_icd_pkg::OUT_CMD_OPCODE
) (
  input  wire logic        clk,
  input  wire logic        rst,
  out_strobe_gen_if.slave  asi_cmd,
  output logic [31:0]      strobe_out,
  output logic             busy,
  output logic             bad_cmd,
  output logic [15:0]      strobe_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] C_PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] C_HOLD_LOAD  = 8'(HOLDOFF_CYCLES - 1);

  generate
    if (PULSE_CYCLES == 0 || PULSE_CYCLES > 255 || HOLDOFF_CYCLES > 255) begin : g_param_check
      $error("out_strobe_gen: PULSE_CYCLES must be 1..255 and HOLDOFF_CYCLES 0..255");
    end
  endgenerate

  state_t      r_state;
  state_t      w_state_n;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_n;
  logic [31:0] w_strobe_n;
  logic        w_bad_n;
  logic [15:0] w_strobe_cnt_n;
  logic        w_ready;
  logic        w_accept;
  logic        w_unused_rsvd;

  // Ready depends only on registered state, never on valid.
  assign w_ready       = (r_state == S_IDLE);
  assign w_accept      = asi_cmd.valid & w_ready;
  assign asi_cmd.ready = w_ready;
  assign busy          = ~w_ready;
  assign w_unused_rsvd = ^asi_cmd.data[23:5];

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_strobe_n     = strobe_out;
    w_bad_n        = 1'b0;
    w_strobe_cnt_n = strobe_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (asi_cmd.data[31:24] == CMD_OUT_OPCODE) begin
            w_state_n      = S_PULSE;
            w_cnt_n        = C_PULSE_LOAD;
            w_strobe_n     = 32'd1 << asi_cmd.data[4:0];
            w_strobe_cnt_n = strobe_cnt + 16'd1;
          end else begin
            w_bad_n = 1'b1;
          end
        end
      end
      S_PULSE: begin
        if (r_cnt == 8'd0) begin
          w_strobe_n = '0;
          // A zero hold-off skips HOLD so ready returns on the falling edge of the strobe.
          if (HOLDOFF_CYCLES == 0) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_HOLD;
            w_cnt_n   = C_HOLD_LOAD;
          end
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        w_strobe_n = '0;
        if (r_cnt == 8'd0) begin
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_n  = S_IDLE;
        w_cnt_n    = 8'd0;
        w_strobe_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      strobe_out <= '0;
      bad_cmd    <= 1'b0;
      strobe_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      strobe_out <= w_strobe_n;
      bad_cmd    <= w_bad_n;
      strobe_cnt <= w_strobe_cnt_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_out_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_out_strobe_gen
// Brief   : Drives two strobe generators (default and 1/0 timing) against a timeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_out_strobe_gen;

  localparam int unsigned P0  = 16;
  localparam int unsigned H0  = 4;
  localparam int unsigned P1  = 1;
  localparam int unsigned H1  = 0;
  localparam logic [7:0]  OPC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] so0, so1;
  logic        busy0, busy1, bad0, bad1;
  logic [15:0] cnt0, cnt1;

  out_strobe_gen_if if0 ();
  out_strobe_gen_if if1 ();

  out_strobe_gen #(.PULSE_CYCLES(P0), .HOLDOFF_CYCLES(H0), .CMD_OUT_OPCODE(OPC)) dut0 (
    .clk(clk), .rst(rst), .asi_cmd(if0.slave),
    .strobe_out(so0), .busy(busy0), .bad_cmd(bad0), .strobe_cnt(cnt0));

  out_strobe_gen #(.PULSE_CYCLES(P1), .HOLDOFF_CYCLES(H1), .CMD_OUT_OPCODE(OPC)) dut1 (
    .clk(clk), .rst(rst), .asi_cmd(if1.slave),
    .strobe_out(so1), .busy(busy1), .bad_cmd(bad1), .strobe_cnt(cnt1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: every output is a function of the last good accept edge and the edge count.
  int          cyc;
  int unsigned pv [2] = '{P0, P1};
  int unsigned hv [2] = '{H0, H1};
  bit          have_acc [2];
  int          acc_cyc  [2];
  int          bad_cyc  [2];
  logic [4:0]  m_idx    [2];
  logic [15:0] m_cnt    [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      have_acc[d] = 1'b0;
      acc_cyc[d]  = 0;
      bad_cyc[d]  = -100;
      m_idx[d]    = 5'd0;
      m_cnt[d]    = 16'd0;
    end
  endfunction

  function automatic bit exp_ready(input int d);
    return !have_acc[d] || (cyc >= acc_cyc[d] + int'(pv[d] + hv[d]));
  endfunction

  function automatic logic [31:0] exp_strobe(input int d);
    if (have_acc[d] && cyc >= acc_cyc[d] && cyc < acc_cyc[d] + int'(pv[d]))
      return 32'd1 << m_idx[d];
    return 32'd0;
  endfunction

  function automatic logic [31:0] make_word(input bit good, input logic [4:0] idx);
    logic [31:0] w;
    w      = $urandom;
    w[4:0] = idx;
    if (good) w[31:24] = OPC;
    else if (w[31:24] == OPC) w[31:24] = ~OPC;
    return w;
  endfunction

  task automatic check_outputs();
    logic [31:0] so;
    logic        rdy, bsy, bad;
    logic [15:0] cnt;
    for (int d = 0; d < 2; d++) begin
      so  = (d == 0) ? so0 : so1;
      rdy = (d == 0) ? if0.ready : if1.ready;
      bsy = (d == 0) ? busy0 : busy1;
      bad = (d == 0) ? bad0 : bad1;
      cnt = (d == 0) ? cnt0 : cnt1;
      check_val($sformatf("strobe%0d", d), so, exp_strobe(d));
      check_val($sformatf("ready%0d", d), {31'd0, rdy}, {31'd0, exp_ready(d)});
      check_val($sformatf("busy%0d", d), {31'd0, bsy}, {31'd0, !exp_ready(d)});
      check_val($sformatf("bad%0d", d), {31'd0, bad}, {31'd0, bad_cyc[d] == cyc});
      check_val($sformatf("cnt%0d", d), {16'd0, cnt}, {16'd0, m_cnt[d]});
    end
  endtask

  task automatic model_accept(input int d, input logic [31:0] w);
    if (w[31:24] == OPC) begin
      have_acc[d] = 1'b1;
      acc_cyc[d]  = cyc;
      m_idx[d]    = w[4:0];
      m_cnt[d]    = m_cnt[d] + 16'd1;
    end else begin
      bad_cyc[d] = cyc;
    end
  endtask

  // One clock: check at the falling edge, present queued words, then commit accepts.
  task automatic step();
    bit acc0, acc1;
    @(negedge clk);
    check_outputs();
    if0.valid = (q0.size() != 0);
    if0.data  = (q0.size() != 0) ? q0[0] : 32'($urandom);
    if1.valid = (q1.size() != 0);
    if1.data  = (q1.size() != 0) ? q1[0] : 32'($urandom);
    acc0 = if0.valid && exp_ready(0);
    acc1 = if1.valid && exp_ready(1);
    @(posedge clk);
    cyc++;
    if (acc0) model_accept(0, q0.pop_front());
    if (acc1) model_accept(1, q1.pop_front());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst       = 1'b1;
    cyc       = 0;
    if0.valid = 1'b0;
    if0.data  = 32'd0;
    if1.valid = 1'b0;
    if1.data  = 32'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single good command on each instance.
    q0.push_back(make_word(1'b1, 5'd5));
    q1.push_back(make_word(1'b1, 5'd31));
    steps(26);

    // Opcode 0x00 is rejected.
    q0.push_back({8'h00, 19'h7FFFF, 5'd3});
    q1.push_back({8'h00, 19'h0, 5'd7});
    steps(4);

    // Back-to-back words with valid held high.
    q0.push_back(make_word(1'b1, 5'd0));
    q0.push_back(make_word(1'b1, 5'd31));
    q1.push_back(make_word(1'b1, 5'd0));
    q1.push_back(make_word(1'b1, 5'd31));
    steps(48);

    // Asynchronous reset in the middle of a pulse.
    q0.push_back(make_word(1'b1, 5'd9));
    steps(6);
    @(negedge clk);
    if0.valid = 1'b0;
    if1.valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("async_clr_strobe0", so0, 32'd0);
    check_val("async_clr_cnt0", {16'd0, cnt0}, 32'd0);
    check_val("async_ready0", {31'd0, if0.ready}, 32'd1);
    q0.delete();
    q1.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic with mixed opcodes, gaps and queued words.
    for (int i = 0; i < 1500; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 5) == 0)
        q0.push_back(make_word($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31))));
      if (q1.size() < 2 && $urandom_range(0, 2) == 0)
        q1.push_back(make_word($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31))));
      step();
    end
    steps(50);

    // Counter wrap: preload 0xFFFF, then one more good command.
    @(negedge clk);
    force dut0.strobe_cnt = 16'hFFFF;
    force dut1.strobe_cnt = 16'hFFFF;
    #1;
    release dut0.strobe_cnt;
    release dut1.strobe_cnt;
    m_cnt[0] = 16'hFFFF;
    m_cnt[1] = 16'hFFFF;
    q0.push_back(make_word(1'b1, 5'd17));
    q1.push_back(make_word(1'b1, 5'd2));
    steps(25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
